// File: rtl/predelay_commutator.sv
// R2MDC pre-delay commutator: delays path 1 by DELAY accepted pairs, then alternates
// straight/swap routing every DELAY pairs. Registered outputs, one-cycle latency.
module predelay_commutator #(
    parameter int DELAY = 16,
    parameter int WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] bf_out0_re,
    input  logic signed [WIDTH-1:0] bf_out0_im,
    input  logic signed [WIDTH-1:0] bf_out1_re,
    input  logic signed [WIDTH-1:0] bf_out1_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] cm_out0_re,
    output logic signed [WIDTH-1:0] cm_out0_im,
    output logic signed [WIDTH-1:0] cm_out1_re,
    output logic signed [WIDTH-1:0] cm_out1_im
);
    localparam int CNT_W = $clog2(2 * DELAY);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] CNT_FILL = CNT_W'(DELAY - 1);

    logic [CNT_W-1:0]        pair_cnt;
    logic                    filled;
    logic signed [WIDTH-1:0] dly_re [DELAY];
    logic signed [WIDTH-1:0] dly_im [DELAY];
    logic signed [WIDTH-1:0] d1_re_p0;
    logic signed [WIDTH-1:0] d1_im_p0;
    logic                    sel_p0;

    assign d1_re_p0 = dly_re[DELAY-1];
    assign d1_im_p0 = dly_im[DELAY-1];
    assign sel_p0   = (pair_cnt >= CNT_HALF);

    // Control: pair counter wraps naturally because 2*DELAY is a power of two
    always_ff @(posedge CLK) begin
        if (RST) begin
            pair_cnt  <= '0;
            filled    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid & filled;
            if (in_valid) begin
                pair_cnt <= pair_cnt + 1'b1;
                if (pair_cnt == CNT_FILL)
                    filled <= 1'b1;
            end
        end
    end

    // Path-1 delay line; contents deliberately survive reset, gated by filled instead
    always_ff @(posedge CLK) begin
        if (in_valid) begin
            dly_re[0] <= bf_out1_re;
            dly_im[0] <= bf_out1_im;
            for (int i = 1; i < DELAY; i++) begin
                dly_re[i] <= dly_re[i-1];
                dly_im[i] <= dly_im[i-1];
            end
        end
    end

    // Stage p0 -> p1: commutator routing into the output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cm_out0_re <= '0;
            cm_out0_im <= '0;
            cm_out1_re <= '0;
            cm_out1_im <= '0;
        end else if (in_valid) begin
            if (sel_p0) begin
                cm_out0_re <= d1_re_p0;
                cm_out0_im <= d1_im_p0;
                cm_out1_re <= bf_out0_re;
                cm_out1_im <= bf_out0_im;
            end else begin
                cm_out0_re <= bf_out0_re;
                cm_out0_im <= bf_out0_im;
                cm_out1_re <= d1_re_p0;
                cm_out1_im <= d1_im_p0;
            end
        end
    end

endmodule

// File: tb/tb_predelay_commutator.sv
// Bench for predelay_commutator: DELAY=2 and DELAY=16 instances driven in parallel and
// compared against a pair-history reference model.
module tb_predelay_commutator;
    localparam int W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic in_valid = 1'b0;
    logic signed [W-1:0] b0r = '0, b0i = '0, b1r = '0, b1i = '0;

    logic                a_vld, b_vld;
    logic signed [W-1:0] a_o0r, a_o0i, a_o1r, a_o1i;
    logic signed [W-1:0] b_o0r, b_o0i, b_o1r, b_o1i;

    always #5 CLK = ~CLK;

    predelay_commutator #(.DELAY(2), .WIDTH(W)) dut_a (
        .CLK(CLK), .RST(RST), .in_valid(in_valid),
        .bf_out0_re(b0r), .bf_out0_im(b0i), .bf_out1_re(b1r), .bf_out1_im(b1i),
        .out_valid(a_vld),
        .cm_out0_re(a_o0r), .cm_out0_im(a_o0i), .cm_out1_re(a_o1r), .cm_out1_im(a_o1i)
    );

    predelay_commutator #(.DELAY(16), .WIDTH(W)) dut_b (
        .CLK(CLK), .RST(RST), .in_valid(in_valid),
        .bf_out0_re(b0r), .bf_out0_im(b0i), .bf_out1_re(b1r), .bf_out1_im(b1i),
        .out_valid(b_vld),
        .cm_out0_re(b_o0r), .cm_out0_im(b_o0i), .cm_out1_re(b_o1r), .cm_out1_im(b_o1i)
    );

    int n_vec = 0;
    int n_fail = 0;
    bit primed = 0;
    bit cap_en = 0;
    logic [31:0] cap[$];

    // Reference model: history of path-1 samples since reset, indexed by pair number
    logic [31:0] hist [2][0:1023];
    int          m_n   [2];
    logic        e_vld [2];
    logic [31:0] e_o0  [2];
    logic [31:0] e_o1  [2];
    bit          k_o0  [2];
    bit          k_o1  [2];

    function automatic logic [31:0] cx(input int v);
        logic [15:0] re, im;
        re = 16'(v);
        im = 16'(v + 100);
        return {re, im};
    endfunction

    task automatic model_update(input int k, input bit rst, input bit vld,
                                input logic [31:0] x0, input logic [31:0] x1);
        int d, n;
        bit swap, dk;
        logic [31:0] d1;
        d = (k == 0) ? 2 : 16;
        if (rst) begin
            m_n[k] = 0; e_vld[k] = 0; e_o0[k] = '0; e_o1[k] = '0; k_o0[k] = 1; k_o1[k] = 1;
        end else if (vld) begin
            n = m_n[k];
            hist[k][n] = x1;
            swap = ((n % (2 * d)) >= d);
            dk = (n >= d);
            d1 = dk ? hist[k][n-d] : '0;
            e_vld[k] = dk;
            if (!swap) begin
                e_o0[k] = x0; k_o0[k] = 1; e_o1[k] = d1; k_o1[k] = dk;
            end else begin
                e_o0[k] = d1; k_o0[k] = dk; e_o1[k] = x0; k_o1[k] = 1;
            end
            m_n[k] = n + 1;
        end else begin
            e_vld[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_valid", {31'd0, a_vld}, {31'd0, e_vld[0]});
        if (k_o0[0]) chk("a_out0", {a_o0r, a_o0i}, e_o0[0]);
        if (k_o1[0]) chk("a_out1", {a_o1r, a_o1i}, e_o1[0]);
        chk("b_valid", {31'd0, b_vld}, {31'd0, e_vld[1]});
        if (k_o0[1]) chk("b_out0", {b_o0r, b_o0i}, e_o0[1]);
        if (k_o1[1]) chk("b_out1", {b_o1r, b_o1i}, e_o1[1]);
        if (cap_en && a_vld) cap.push_back({a_o0r, a_o1r});
    endtask

    task automatic step(input bit rst, input bit vld, input logic [31:0] x0, input logic [31:0] x1);
        @(negedge CLK);
        if (primed) check_all();
        RST = rst;
        in_valid = vld;
        {b0r, b0i} = x0;
        {b1r, b1i} = x1;
        model_update(0, rst, vld, x0, x1);
        model_update(1, rst, vld, x0, x1);
        primed = 1;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, '0, '0);
    endtask

    task automatic check_capture(input string tag, input logic [31:0] exp[$]);
        chk({tag, "_count"}, 32'(cap.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk(tag, cap[i], exp[i]);
        cap.delete();
    endtask

    logic [31:0] exp_t2[$];
    logic [31:0] exp_t5[$];

    initial begin
        exp_t2 = '{{16'd20, 16'd12}, {16'd21, 16'd13}, {16'd14, 16'd22}, {16'd15, 16'd23}};
        exp_t5 = '{{16'd40, 16'd32}, {16'd41, 16'd33}};

        // T1: reset
        do_reset(2);

        // T2: fill and commutate
        cap_en = 1;
        for (int i = 0; i < 6; i++) step(0, 1, cx(10 + i), cx(20 + i));
        step(0, 0, '0, '0);
        cap_en = 0;
        check_capture("t2_seq", exp_t2);

        // T3: stall of 3 cycles between pairs 3 and 4
        do_reset(2);
        cap_en = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) for (int g = 0; g < 3; g++) step(0, 0, cx(999), cx(999));
            step(0, 1, cx(10 + i), cx(20 + i));
        end
        step(0, 0, '0, '0);
        cap_en = 0;
        check_capture("t3_seq", exp_t2);

        // T4: 64 continuous random pairs
        do_reset(1);
        for (int i = 0; i < 64; i++) step(0, 1, $urandom, $urandom);

        // T5: reset mid-frame after pair 3, then resume
        do_reset(1);
        for (int i = 0; i < 4; i++) step(0, 1, cx(10 + i), cx(20 + i));
        do_reset(1);
        cap_en = 1;
        for (int i = 0; i < 4; i++) step(0, 1, cx(30 + i), cx(40 + i));
        step(0, 0, '0, '0);
        cap_en = 0;
        check_capture("t5_seq", exp_t5);

        // T6: 96 random pairs with occasional gaps, exercising the DELAY=16 wrap
        do_reset(1);
        for (int i = 0; i < 96; i++) begin
            if ($urandom_range(0, 7) == 0) step(0, 0, $urandom, $urandom);
            step(0, 1, $urandom, $urandom);
        end
        step(0, 0, '0, '0);
        step(0, 0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
